// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one active-low row at a time, reads the columns back,
// debounces a single key and reports it as a one-clock key_valid pulse plus a held flag.
module keypad_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEB,
        ST_HELD
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       col_meta_q;
    logic [3:0]       col_s_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       row_q, row_d;
    logic [1:0]       lat_row_q, lat_row_d;
    logic [3:0]       lat_col_q, lat_col_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic             tick;
    logic             one_low;
    logic [1:0]       row_idx;
    logic [1:0]       lat_col_idx;
    logic [3:0]       row_rot;

    // Columns are asynchronous to clk; two flops before any decision uses them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
        end else begin
            col_meta_q <= col_in;
            col_s_q    <= col_meta_q;
        end
    end

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + 1'b1;

    assign one_low = ($countones(~col_s_q) == 1);
    assign row_rot = {row_q[2:0], row_q[3]};

    always_comb begin
        row_idx = 2'd0;
        case (row_q)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_comb begin
        lat_col_idx = 2'd0;
        case (lat_col_q)
            4'b1110: lat_col_idx = 2'd0;
            4'b1101: lat_col_idx = 2'd1;
            4'b1011: lat_col_idx = 2'd2;
            4'b0111: lat_col_idx = 2'd3;
            default: lat_col_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        lat_row_d   = lat_row_q;
        lat_col_d   = lat_col_q;
        deb_cnt_d   = deb_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    // Only a clean single-column hit is latched; ghosting keeps the scan moving.
                    if (one_low) begin
                        lat_row_d = row_idx;
                        lat_col_d = col_s_q;
                        deb_cnt_d = '0;
                        state_d   = ST_DEB;
                    end else begin
                        row_d = row_rot;
                    end
                end
                ST_DEB: begin
                    if (col_s_q == lat_col_q) begin
                        if (deb_cnt_q == CNT_LAST) begin
                            key_code_d  = {lat_row_q, lat_col_idx};
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            rel_cnt_d   = '0;
                            state_d     = ST_HELD;
                        end else begin
                            deb_cnt_d = deb_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // Any low column, even from another key, restarts the release count.
                    if (col_s_q == 4'hF) begin
                        if (rel_cnt_q == CNT_LAST) begin
                            key_held_d = 1'b0;
                            rel_cnt_d  = '0;
                            row_d      = row_rot;
                            state_d    = ST_SCAN;
                        end else begin
                            rel_cnt_d = rel_cnt_q + 1'b1;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            div_q       <= '0;
            row_q       <= 4'b1110;
            lat_row_q   <= 2'd0;
            lat_col_q   <= 4'hF;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            row_q       <= row_d;
            lat_row_q   <= lat_row_d;
            lat_col_q   <= lat_col_d;
            deb_cnt_q   <= deb_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row_out   = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a fast scan (4 clk per tick) and 3-tick debounce.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] col_in = 4'hF;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int dbl_cnt = 0;
    logic prev_valid = 1'b0;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping: total pulses and any pulse lasting longer than one clk.
    always @(posedge clk) begin
        if (key_valid) pulses <= pulses + 1;
        if (key_valid && prev_valid) dbl_cnt <= dbl_cnt + 1;
        prev_valid <= key_valid;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Waits for row_out to newly arrive at pat, so the scan divider is at its start.
    task automatic wait_row(input logic [3:0] pat, output bit ok);
        int n;
        n = 0;
        while (row_out == pat && n < 40) begin step(); n++; end
        while (row_out != pat && n < 40) begin step(); n++; end
        ok = (row_out == pat);
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!key_valid && n < limit) begin step(); n++; end
    endtask

    task automatic wait_release(input int limit, output int n);
        n = 0;
        while (key_held && n < limit) begin step(); n++; end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL reset_row got=%b want=1110", row_out); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code got=%0d want=0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got=%b want=0", key_held); end
        $display("reset: row=%b code=%0d valid=%b held=%b", row_out, key_code, key_valid, key_held);
    endtask

    task automatic test_idle_scan();
        logic [3:0] rows [4];
        rows[0] = 4'b1110; rows[1] = 4'b1101; rows[2] = 4'b1011; rows[3] = 4'b0111;
        col_in = 4'hF;
        @(negedge clk) rst_n = 1'b1;
        for (int n = 0; n <= 16; n++) begin
            checks++;
            if (row_out !== rows[(n / 4) % 4]) begin
                errors++; $display("FAIL idle_row cycle=%0d got=%b want=%b", n, row_out, rows[(n / 4) % 4]);
            end
            checks++;
            if (key_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cycle=%0d got=1 want=0", n); end
            if (n < 16) step();
        end
        $display("idle: scanned 16 clk, row=%b", row_out);
    endtask

    task automatic test_press();
        bit ok; int n; int p0;
        wait_row(4'b1011, ok);
        checks++; if (!ok) begin errors++; $display("FAIL press_row_wait got=%b want=1011", row_out); end
        p0 = pulses;
        col_in = 4'b1101;
        wait_valid(40, n);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press_pulse got=0 want=1"); end
        checks++; if (n != 16) begin errors++; $display("FAIL press_latency got=%0d want=16", n); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL press_code got=%0d want=9", key_code); end
        repeat (20) step();
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL press_pulse_count got=%0d want=1", pulses - p0); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held got=%b want=1", key_held); end
        checks++; if (row_out !== 4'b1011) begin errors++; $display("FAIL press_row_frozen got=%b want=1011", row_out); end
        $display("press: row=2 col=1 code=%0d latency=%0d held=%b", key_code, n, key_held);
    endtask

    task automatic test_release();
        int n;
        col_in = 4'hF;
        wait_release(40, n);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held got=1 want=0"); end
        checks++; if (n != 12) begin errors++; $display("FAIL release_latency got=%0d want=12", n); end
        checks++; if (row_out !== 4'b0111) begin errors++; $display("FAIL release_row got=%b want=0111", row_out); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL release_code got=%0d want=9", key_code); end
        repeat (4) step();
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL release_resume got=%b want=1110", row_out); end
        $display("release: latency=%0d row=%b", n, row_out);
    endtask

    task automatic test_bounce();
        bit ok; int n; int p0;
        wait_row(4'b1011, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bounce_row_wait got=%b want=1011", row_out); end
        p0 = pulses;
        for (int t = 0; t < 6; t++) begin
            col_in = (t % 2 == 0) ? 4'b1101 : 4'hF;
            repeat (4) step();
        end
        checks++; if (pulses - p0 != 0) begin errors++; $display("FAIL bounce_no_pulse got=%0d want=0", pulses - p0); end
        checks++; if (row_out !== 4'b1011) begin errors++; $display("FAIL bounce_row_hold got=%b want=1011", row_out); end
        repeat (4) step();
        checks++; if (row_out !== 4'b0111) begin errors++; $display("FAIL bounce_resume got=%b want=0111", row_out); end
        wait_row(4'b1011, ok);
        col_in = 4'b1101;
        wait_valid(40, n);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL bounce_stable_pulse got=0 want=1"); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL bounce_code got=%0d want=9", key_code); end
        step();
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL bounce_pulse_count got=%0d want=1", pulses - p0); end
        col_in = 4'hF;
        wait_release(40, n);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_release got=1 want=0"); end
        $display("bounce: stable press code=%0d", key_code);
    endtask

    task automatic test_ghost_and_held();
        bit ok; int n; int p0; int rot;
        logic [3:0] prev;
        p0 = pulses;
        col_in = 4'b1100;
        prev = row_out;
        rot = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (row_out != prev) rot++;
            prev = row_out;
        end
        checks++; if (rot != 6) begin errors++; $display("FAIL ghost_rotations got=%0d want=6", rot); end
        checks++; if (pulses - p0 != 0) begin errors++; $display("FAIL ghost_no_pulse got=%0d want=0", pulses - p0); end
        $display("ghost: col=1100 rotations=%0d", rot);
        col_in = 4'hF;
        wait_row(4'b1101, ok);
        p0 = pulses;
        col_in = 4'b0111;
        wait_valid(40, n);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL held_first_pulse got=0 want=1"); end
        checks++; if (key_code !== 4'd7) begin errors++; $display("FAIL held_first_code got=%0d want=7", key_code); end
        col_in = 4'b1110;
        repeat (30) step();
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL held_second_key got=%0d want=1", pulses - p0); end
        checks++; if (key_code !== 4'd7) begin errors++; $display("FAIL held_code_kept got=%0d want=7", key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL held_still got=%b want=1", key_held); end
        col_in = 4'hF;
        wait_release(40, n);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL held_release got=1 want=0"); end
        $display("held: first key code=7, second key ignored");
    endtask

    task automatic test_corner_keys();
        logic [3:0] rows [3];
        logic [3:0] cols [3];
        logic [3:0] codes [3];
        bit ok; int n;
        rows[0] = 4'b1110; cols[0] = 4'b1110; codes[0] = 4'd0;
        rows[1] = 4'b0111; cols[1] = 4'b0111; codes[1] = 4'd15;
        rows[2] = 4'b1011; cols[2] = 4'b0111; codes[2] = 4'd11;
        for (int k = 0; k < 3; k++) begin
            wait_row(rows[k], ok);
            col_in = cols[k];
            wait_valid(40, n);
            checks++;
            if (key_valid !== 1'b1 || key_code !== codes[k]) begin
                errors++; $display("FAIL corner_code%0d got=%0d valid=%b want=%0d", k, key_code, key_valid, codes[k]);
            end
            col_in = 4'hF;
            wait_release(40, n);
            checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL corner_release%0d got=1 want=0", k); end
            $display("corner: row=%b col=%b code=%0d", rows[k], cols[k], key_code);
        end
    endtask

    task automatic test_reset_mid_deb();
        bit ok; int p0;
        wait_row(4'b1011, ok);
        col_in = 4'b1101;
        repeat (6) step();
        checks++; if (row_out !== 4'b1011 || key_held !== 1'b0) begin
            errors++; $display("FAIL middeb_pre row=%b held=%b want 1011/0", row_out, key_held);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL middeb_row got=%b want=1110", row_out); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL middeb_code got=%0d want=0", key_code); end
        checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++; $display("FAIL middeb_flags valid=%b held=%b want 0/0", key_valid, key_held);
        end
        col_in = 4'hF;
        p0 = pulses;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) step();
        checks++; if (row_out !== 4'b1101) begin errors++; $display("FAIL middeb_rescan got=%b want=1101", row_out); end
        repeat (36) step();
        checks++; if (pulses - p0 != 0 || key_held !== 1'b0) begin
            errors++; $display("FAIL middeb_no_pulse pulses=%0d held=%b want 0/0", pulses - p0, key_held);
        end
        $display("reset mid-DEB: row=%b code=%0d", row_out, key_code);
    endtask

    task automatic test_single_cycle_pulses();
        checks++; if (dbl_cnt != 0) begin errors++; $display("FAIL pulse_width got=%0d long pulses want=0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press();
        test_release();
        test_bounce();
        test_ghost_and_held();
        test_corner_keys();
        test_reset_mid_deb();
        test_single_cycle_pulses();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
